// File: rtl/ss_bus_controller.sv
// ss_bus_controller
//
// Savestate bus initiator. It walks bus addresses 0 .. ADDRESS_COUNT-1 and
// moves data between the savestate bus and a host-side word stream.
//   save: read each address after it has settled, then emit the word on the
//         save_* valid/ready stream.
//   load: accept a word from the load_* valid/ready stream, then write it to
//         the current address.
// Between transactions the bus is parked at IDLE_ADDR for one cycle, so every
// responder sees an address change.
//
// Ports
//   clk, reset            sole clock; synchronous active-high reset
//   start_save/start_load start pulses, honoured only when idle (save wins)
//   busy, done            sequence in progress / one-cycle completion pulse
//   save_data/valid/ready save word stream (initiator -> host)
//   load_data/valid/ready load word stream (host -> initiator)
//   ss_bus_addr/wdata/wren/reset_n/rdata  shared savestate bus

package ss_addresses;
    localparam int SS_BUS_WIDTH  = 8;
    localparam int SS_DATA_WIDTH = 16;
endpackage

module ss_bus_controller
    import ss_addresses::*;
#(
    parameter int unsigned                ADDRESS_COUNT = 16,
    parameter int unsigned                SETTLE_CYCLES = 20,
    parameter logic [SS_BUS_WIDTH-1:0]    IDLE_ADDR     = '1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start_save,
    input  logic                       start_load,
    output logic                       busy,
    output logic                       done,
    output logic [SS_DATA_WIDTH-1:0]   save_data,
    output logic                       save_valid,
    input  logic                       save_ready,
    input  logic [SS_DATA_WIDTH-1:0]   load_data,
    input  logic                       load_valid,
    output logic                       load_ready,
    output logic [SS_BUS_WIDTH-1:0]    ss_bus_addr,
    output logic [SS_DATA_WIDTH-1:0]   ss_bus_wdata,
    output logic                       ss_bus_wren,
    output logic                       ss_bus_reset_n,
    input  logic [SS_DATA_WIDTH-1:0]   ss_bus_rdata
);

    localparam int IW = $clog2(ADDRESS_COUNT + 1);
    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(ADDRESS_COUNT - 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PARK,
        S_SAVE_HOLD,
        S_SAVE_EMIT,
        S_LOAD_WAIT,
        S_LOAD_HOLD,
        S_FINISH
    } state_t;

    state_t                     state, state_nx;
    logic [IW-1:0]              idx, idx_nx;
    logic [CW-1:0]              cnt, cnt_nx;
    logic                       saving, saving_nx;
    logic [SS_BUS_WIDTH-1:0]    addr_nx;
    logic [SS_DATA_WIDTH-1:0]   wdata_nx, save_data_nx;
    logic                       wren_nx, save_valid_nx, load_ready_nx;
    logic                       busy_nx, done_nx;

    // Never issue restore-default on the bus.
    assign ss_bus_reset_n = 1'b1;

    // Every output is computed one cycle ahead here and registered below, so
    // output values always match the state they are registered alongside.
    always_comb begin
        state_nx      = state;
        idx_nx        = idx;
        cnt_nx        = cnt;
        saving_nx     = saving;
        addr_nx       = ss_bus_addr;
        wdata_nx      = ss_bus_wdata;
        wren_nx       = ss_bus_wren;
        save_data_nx  = save_data;
        save_valid_nx = save_valid;
        load_ready_nx = load_ready;
        busy_nx       = busy;
        done_nx       = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (start_save) begin
                    idx_nx    = '0;
                    cnt_nx    = '0;
                    saving_nx = 1'b1;
                    busy_nx   = 1'b1;
                    addr_nx   = '0;
                    state_nx  = S_SAVE_HOLD;
                end else if (start_load) begin
                    idx_nx        = '0;
                    saving_nx     = 1'b0;
                    busy_nx       = 1'b1;
                    load_ready_nx = 1'b1;
                    state_nx      = S_LOAD_WAIT;
                end
            end

            S_SAVE_HOLD: begin
                if (cnt == LAST_CNT) begin
                    save_data_nx  = ss_bus_rdata;
                    save_valid_nx = 1'b1;
                    addr_nx       = IDLE_ADDR;
                    state_nx      = S_SAVE_EMIT;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end

            S_SAVE_EMIT: begin
                if (save_ready) begin
                    save_valid_nx = 1'b0;
                    idx_nx        = idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        done_nx  = 1'b1;
                        busy_nx  = 1'b0;
                        state_nx = S_FINISH;
                    end else begin
                        state_nx = S_PARK;
                    end
                end
            end

            S_PARK: begin
                if (saving) begin
                    addr_nx  = SS_BUS_WIDTH'(idx);
                    cnt_nx   = '0;
                    state_nx = S_SAVE_HOLD;
                end else begin
                    load_ready_nx = 1'b1;
                    state_nx      = S_LOAD_WAIT;
                end
            end

            S_LOAD_WAIT: begin
                if (load_valid) begin
                    wdata_nx      = load_data;
                    addr_nx       = SS_BUS_WIDTH'(idx);
                    wren_nx       = 1'b1;
                    load_ready_nx = 1'b0;
                    cnt_nx        = '0;
                    state_nx      = S_LOAD_HOLD;
                end
            end

            S_LOAD_HOLD: begin
                if (cnt == LAST_CNT) begin
                    wren_nx = 1'b0;
                    addr_nx = IDLE_ADDR;
                    idx_nx  = idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        done_nx  = 1'b1;
                        busy_nx  = 1'b0;
                        state_nx = S_FINISH;
                    end else begin
                        state_nx = S_PARK;
                    end
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end

            S_FINISH: begin
                state_nx = S_IDLE;
            end

            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            idx          <= '0;
            cnt          <= '0;
            saving       <= 1'b0;
            ss_bus_addr  <= IDLE_ADDR;
            ss_bus_wdata <= '0;
            ss_bus_wren  <= 1'b0;
            save_data    <= '0;
            save_valid   <= 1'b0;
            load_ready   <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_nx;
            idx          <= idx_nx;
            cnt          <= cnt_nx;
            saving       <= saving_nx;
            ss_bus_addr  <= addr_nx;
            ss_bus_wdata <= wdata_nx;
            ss_bus_wren  <= wren_nx;
            save_data    <= save_data_nx;
            save_valid   <= save_valid_nx;
            load_ready   <= load_ready_nx;
            busy         <= busy_nx;
            done         <= done_nx;
        end
    end

endmodule

// File: tb/tb_ss_bus_controller.sv
// Testbench for ss_bus_controller: directed save/load sequences against a
// three-word responder model (ADDRESS_COUNT=3) plus a single-address instance
// (ADDRESS_COUNT=1), both with SETTLE_CYCLES=4.

module tb_ss_bus_controller;
    import ss_addresses::*;

    localparam logic [SS_BUS_WIDTH-1:0] IDLE = '1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // ADDRESS_COUNT = 3 instance
    logic                      start_save, start_load, busy, done;
    logic [SS_DATA_WIDTH-1:0]  save_data, load_data, wdata, rdata;
    logic                      save_valid, save_ready, load_valid, load_ready;
    logic [SS_BUS_WIDTH-1:0]   addr;
    logic                      wren, reset_n;

    // ADDRESS_COUNT = 1 instance
    logic                      start_save1, start_load1, busy1, done1;
    logic [SS_DATA_WIDTH-1:0]  save_data1, load_data1, wdata1, rdata1;
    logic                      save_valid1, save_ready1, load_valid1, load_ready1;
    logic [SS_BUS_WIDTH-1:0]   addr1;
    logic                      wren1, reset_n1;

    int checks = 0;
    int errors = 0;

    ss_bus_controller #(.ADDRESS_COUNT(3), .SETTLE_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .start_save(start_save), .start_load(start_load),
        .busy(busy), .done(done), .save_data(save_data), .save_valid(save_valid),
        .save_ready(save_ready), .load_data(load_data), .load_valid(load_valid),
        .load_ready(load_ready), .ss_bus_addr(addr), .ss_bus_wdata(wdata),
        .ss_bus_wren(wren), .ss_bus_reset_n(reset_n), .ss_bus_rdata(rdata)
    );

    ss_bus_controller #(.ADDRESS_COUNT(1), .SETTLE_CYCLES(4)) dut1 (
        .clk(clk), .reset(reset), .start_save(start_save1), .start_load(start_load1),
        .busy(busy1), .done(done1), .save_data(save_data1), .save_valid(save_valid1),
        .save_ready(save_ready1), .load_data(load_data1), .load_valid(load_valid1),
        .load_ready(load_ready1), .ss_bus_addr(addr1), .ss_bus_wdata(wdata1),
        .ss_bus_wren(wren1), .ss_bus_reset_n(reset_n1), .ss_bus_rdata(rdata1)
    );

    // Responder model: three words at addresses 0..2, preloadable.
    logic [SS_DATA_WIDTH-1:0] mem [3];
    logic [SS_DATA_WIDTH-1:0] pv  [3];
    logic                     preset = 1'b0;

    always @(posedge clk) begin
        if (preset) begin
            for (int i = 0; i < 3; i++) mem[i] <= pv[i];
        end else if (wren && addr < 8'd3) begin
            mem[addr[1:0]] <= wdata;
        end
    end

    assign rdata  = (addr < 8'd3) ? mem[addr[1:0]] : '0;
    assign rdata1 = (addr1 == 8'd0) ? 16'h003C : '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic preload(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
        pv[0] = a; pv[1] = b; pv[2] = c;
        preset = 1'b1;
        @(negedge clk);
        preset = 1'b0;
    endtask

    // Full three-word save; optional stall on one word, simultaneous start,
    // and a retrigger attempt while busy.
    task automatic run_save(input bit both, input int stall_word, input bit retrigger);
        logic [15:0] exp;
        start_save = 1'b1;
        start_load = both;
        @(negedge clk);
        start_save = 1'b0;
        start_load = 1'b0;
        for (int w = 0; w < 3; w++) begin
            for (int k = 0; k < 4; k++) begin
                check("save_hold_addr", addr, w);
                check("save_hold_wren", wren, 0);
                check("save_hold_valid", save_valid, 0);
                check("save_hold_busy", busy, 1);
                check("save_hold_load_ready", load_ready, 0);
                check("save_hold_done", done, 0);
                if (retrigger && w == 0 && k == 1) begin
                    start_save = 1'b1;
                    start_load = 1'b1;
                end
                @(negedge clk);
                start_save = 1'b0;
                start_load = 1'b0;
            end
            exp = 16'(16'h0011 * (w + 1));
            check("save_emit_valid", save_valid, 1);
            check("save_emit_data", save_data, exp);
            check("save_emit_addr", addr, IDLE);
            if (w == stall_word) begin
                save_ready = 1'b0;
                for (int s = 0; s < 10; s++) begin
                    @(negedge clk);
                    check("stall_valid", save_valid, 1);
                    check("stall_data", save_data, exp);
                    check("stall_addr", addr, IDLE);
                    check("stall_busy", busy, 1);
                end
                save_ready = 1'b1;
            end
            @(negedge clk);
            if (w < 2) begin
                check("save_park_addr", addr, IDLE);
                check("save_park_valid", save_valid, 0);
                check("save_park_done", done, 0);
                check("save_park_load_ready", load_ready, 0);
                @(negedge clk);
            end else begin
                check("save_done", done, 1);
                check("save_done_busy", busy, 0);
                check("save_done_addr", addr, IDLE);
                @(negedge clk);
                check("save_after_done", done, 0);
                check("save_after_busy", busy, 0);
                check("save_after_load_ready", load_ready, 0);
            end
        end
    endtask

    // Full three-word load with idle gaps before each word.
    task automatic run_load(input logic [15:0] d0, input logic [15:0] d1, input logic [15:0] d2,
                            input int g0, input int g1, input int g2);
        logic [15:0] d [3];
        int          g [3];
        d[0] = d0; d[1] = d1; d[2] = d2;
        g[0] = g0; g[1] = g1; g[2] = g2;
        start_load = 1'b1;
        @(negedge clk);
        start_load = 1'b0;
        for (int w = 0; w < 3; w++) begin
            check("load_wait_ready", load_ready, 1);
            check("load_wait_addr", addr, IDLE);
            check("load_wait_wren", wren, 0);
            check("load_wait_busy", busy, 1);
            for (int s = 0; s < g[w]; s++) begin
                @(negedge clk);
                check("load_gap_ready", load_ready, 1);
                check("load_gap_wren", wren, 0);
            end
            load_valid = 1'b1;
            load_data  = d[w];
            @(negedge clk);
            load_valid = 1'b0;
            load_data  = 16'hDEAD;
            for (int k = 0; k < 4; k++) begin
                check("load_hold_addr", addr, w);
                check("load_hold_wren", wren, 1);
                check("load_hold_wdata", wdata, d[w]);
                check("load_hold_ready", load_ready, 0);
                @(negedge clk);
            end
            check("load_post_wren", wren, 0);
            check("load_post_addr", addr, IDLE);
            check("load_post_ready", load_ready, 0);
            if (w < 2) begin
                check("load_park_done", done, 0);
                @(negedge clk);
            end else begin
                check("load_done", done, 1);
                check("load_done_busy", busy, 0);
                @(negedge clk);
                check("load_after_done", done, 0);
            end
        end
        for (int i = 0; i < 3; i++) check("load_mem", mem[i], d[i]);
    endtask

    initial begin
        reset       = 1'b1;
        start_save  = 1'b0; start_load  = 1'b0;
        save_ready  = 1'b1; load_valid  = 1'b0; load_data  = 16'hDEAD;
        start_save1 = 1'b0; start_load1 = 1'b0;
        save_ready1 = 1'b0; load_valid1 = 1'b0; load_data1 = '0;
        repeat (2) @(negedge clk);

        check("rst_addr", addr, IDLE);
        check("rst_wdata", wdata, 0);
        check("rst_wren", wren, 0);
        check("rst_reset_n", reset_n, 1);
        check("rst_save_data", save_data, 0);
        check("rst_save_valid", save_valid, 0);
        check("rst_load_ready", load_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_addr1", addr1, IDLE);
        reset = 1'b0;
        @(negedge clk);

        preload(16'h0011, 16'h0022, 16'h0033);
        run_save(1'b0, -1, 1'b0);
        run_save(1'b0, 1, 1'b0);
        run_save(1'b1, -1, 1'b1);

        run_load(16'h00A5, 16'h005A, 16'h00FF, 0, 3, 1);

        // Reset in the second cycle of the first write.
        start_load = 1'b1;
        @(negedge clk);
        start_load = 1'b0;
        load_valid = 1'b1;
        load_data  = 16'h0077;
        @(negedge clk);
        load_valid = 1'b0;
        check("rst_hold1_wren", wren, 1);
        @(negedge clk);
        check("rst_hold2_wren", wren, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_addr", addr, IDLE);
        check("midrst_wren", wren, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_load_ready", load_ready, 0);
        @(negedge clk);
        check("midrst_idle_done", done, 0);
        run_load(16'h1234, 16'h0F0F, 16'h0001, 1, 0, 2);

        // Single-address save: no park, done right after the handshake.
        start_save1 = 1'b1;
        @(negedge clk);
        start_save1 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("one_hold_addr", addr1, 0);
            check("one_hold_valid", save_valid1, 0);
            check("one_hold_busy", busy1, 1);
            @(negedge clk);
        end
        check("one_emit_valid", save_valid1, 1);
        check("one_emit_data", save_data1, 16'h003C);
        check("one_emit_addr", addr1, IDLE);
        @(negedge clk);
        check("one_stalled_valid", save_valid1, 1);
        save_ready1 = 1'b1;
        @(negedge clk);
        save_ready1 = 1'b0;
        check("one_done", done1, 1);
        check("one_done_busy", busy1, 0);
        check("one_done_valid", save_valid1, 0);
        @(negedge clk);
        check("one_after_done", done1, 0);
        check("one_after_addr", addr1, IDLE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ss_bus_controller.md
# ss_bus_controller

Savestate bus initiator that drives the shared savestate bus (`ss_bus_*`) and walks every bus address in sequence. It converts between that bus and a host-side word stream: a save reads each address and emits its data on a valid/ready output stream; a load accepts words from a valid/ready input stream and writes each one. It sits between the savestate bridge (host / APF side) and all savestate responders, including the register banks and the memory adapters.

## Interface
Parameters:
- `ADDRESS_COUNT`, default 16: number of bus addresses walked, starting at 0. Must be ≥ 1.
- `SETTLE_CYCLES`, default 20: cycles each address is held before read capture or write release. Must be ≥ the slowest responder's latency + 2.
- `IDLE_ADDR`, default all-ones (`SS_BUS_WIDTH`): parked address; must lie outside every responder range.

Ports (widths from `ss_addresses`):
- `clk` in 1: sole clock.
- `reset` in 1: synchronous, active-high.
- `start_save` in 1: pulse that begins a save.
- `start_load` in 1: pulse that begins a load.
- `busy` out 1: high from the accepted start until `done`.
- `done` out 1: single-cycle pulse when the sequence completes.
- `save_data` out `SS_DATA_WIDTH`: word read from the bus.
- `save_valid` out 1 / `save_ready` in 1: save-stream handshake.
- `load_data` in `SS_DATA_WIDTH`: word to write.
- `load_valid` in 1 / `load_ready` out 1: load-stream handshake.
- `ss_bus_addr` out `SS_BUS_WIDTH`: bus address.
- `ss_bus_wdata` out `SS_DATA_WIDTH`: data driven to responders.
- `ss_bus_wren` out 1: write strobe.
- `ss_bus_reset_n` out 1: tied high; this block never issues a restore-default.
- `ss_bus_rdata` in `SS_DATA_WIDTH`: OR/mux of all responder outputs.

## Operation
- States: IDLE, PARK, SAVE_HOLD, SAVE_EMIT, LOAD_WAIT, LOAD_HOLD, FINISH.
- Address index `idx` is `$clog2(ADDRESS_COUNT+1)` bits wide. Settle counter is `$clog2(SETTLE_CYCLES+1)` bits wide.
- IDLE:
  - On `start_save`: `idx`=0, `busy`=1, go to SAVE_HOLD.
  - On `start_load`: `idx`=0, `busy`=1, go to LOAD_WAIT.
  - If both are high in the same cycle, save wins.
  - Starts outside IDLE are ignored.
- SAVE_HOLD:
  - Drive `ss_bus_addr`=`idx` and `ss_bus_wren`=0; count `SETTLE_CYCLES` cycles.
  - On the last cycle, register `ss_bus_rdata` into `save_data` and go to SAVE_EMIT.
- SAVE_EMIT:
  - Bus is parked (`IDLE_ADDR`); `save_valid`=1; `save_data` is held stable until accepted.
  - On `save_valid && save_ready`: `idx`+1. If `idx` was `ADDRESS_COUNT-1`, go to FINISH; otherwise go to PARK, then SAVE_HOLD.
- LOAD_WAIT:
  - Bus is parked; `load_ready`=1.
  - On `load_valid && load_ready`: latch `load_data` into `ss_bus_wdata` and go to LOAD_HOLD.
- LOAD_HOLD:
  - `ss_bus_addr`=`idx`, `ss_bus_wren`=1, and `ss_bus_wdata` are all presented in the same first cycle and held for `SETTLE_CYCLES` cycles.
  - Then deassert `ss_bus_wren`, `idx`+1. If this was the last index, go to FINISH; otherwise go to PARK, then LOAD_WAIT.
- PARK: exactly one cycle at `IDLE_ADDR` with `ss_bus_wren`=0. This guarantees every responder sees an address change between transactions.
- FINISH: `done`=1 for one cycle, `busy`=0, return to IDLE.
- Whenever `ss_bus_wren`=0, the bus is at `IDLE_ADDR` except during SAVE_HOLD. `ss_bus_wren` is never high while at `IDLE_ADDR`.
- `reset` in any state:
  - Go to IDLE; all outputs return to reset values on the next edge.
  - Any pending stream word is dropped.
  - A write in flight is truncated (the responder sees the address leave its range and resets itself).

## Timing
- Reset values: `ss_bus_addr`=`IDLE_ADDR`, `ss_bus_wdata`=0, `ss_bus_wren`=0, `ss_bus_reset_n`=1, `save_data`=0, `save_valid`=0, `load_ready`=0, `busy`=0, `done`=0.
- All outputs are registered.
- Start pulse at edge N: `busy`=1 and the first address (save) or `load_ready` (load) are visible after edge N+1.
- Save, per word: `SETTLE_CYCLES` cycles of address, then `save_valid` the next cycle. With `save_ready` held high, the word period is `SETTLE_CYCLES`+2 (hold + emit + park). The final word has no park; FINISH follows the emit handshake.
- Load, per word: 1 cycle handshake + `SETTLE_CYCLES` hold + 1 park.
- `done` is asserted the cycle after the last handshake (save) or the last hold cycle (load).
- `load_ready` is high only in LOAD_WAIT. `save_valid` is high only in SAVE_EMIT.

## Test plan
- Save, `ADDRESS_COUNT`=3, `SETTLE_CYCLES`=4, model responders return 0x11, 0x22, 0x33, `save_ready`=1 → `save_data` sequence 0x11, 0x22, 0x33; each address held 4 cycles; one `IDLE_ADDR` cycle between addresses; `done` fires once; `busy` drops the same cycle.
- Save backpressure: `save_ready` low for 10 cycles on word 1 → `save_valid` and `save_data` stay stable; bus stays parked; no address advance.
- Load of 0xA5, 0x5A, 0xFF with gaps in `load_valid` → each write shows `ss_bus_addr`=`idx`, `ss_bus_wren`=1, and the data together for exactly 4 cycles; responder memories match.
- `start_save` and `start_load` in the same cycle → save sequence runs; `load_ready` is never asserted. A second start while `busy` is ignored.
- `reset` in cycle 2 of a LOAD_HOLD → next edge shows `ss_bus_addr`=`IDLE_ADDR`, `ss_bus_wren`=0, `busy`=0, no `done`. A fresh `start_load` then restarts at `idx` 0.
- `ADDRESS_COUNT`=1 save → single word emitted, no PARK cycle, `done` on the cycle after the handshake.
